// File: rtl/button_pkg.sv
// Shared constants for the board push-button front end. The channel order
// matches the game core ui_in[3:0] bit order.
package button_pkg;

    typedef enum int unsigned {
        BTN_UP    = 0,
        BTN_LEFT  = 1,
        BTN_RIGHT = 2,
        BTN_DOWN  = 3
    } btn_idx_e;

    localparam int N_BTN_DEFAULT           = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One push-button: 2-flop synchroniser, stable-count filter and registered
// press/release edge pulses.
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_level_q, btn_level_d;
    logic             btn_press_q, btn_press_d;
    logic             btn_release_q, btn_release_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        cnt_d         = '0;
        btn_level_d   = btn_level_q;
        btn_press_d   = 1'b0;
        btn_release_d = 1'b0;
        if (ena) begin
            if (sync2_q == btn_level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                btn_level_d   = sync2_q;
                btn_press_d   = sync2_q;
                btn_release_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // The synchroniser runs regardless of ena so a re-enabled filter sees
    // current button state rather than a stale sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            cnt_q         <= '0;
            btn_level_q   <= 1'b0;
            btn_press_q   <= 1'b0;
            btn_release_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so sync2_q takes the old sync1_q
            // and the filter sees the pre-edge values of every flop.
            sync1_q       <= btn_raw;
            sync2_q       <= sync1_q;
            cnt_q         <= cnt_d;
            btn_level_q   <= btn_level_d;
            btn_press_q   <= btn_press_d;
            btn_release_q <= btn_release_d;
        end
    end

    assign btn_level   = btn_level_q;
    assign btn_press   = btn_press_q;
    assign btn_release = btn_release_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw asynchronous push-buttons into clean levels and
// one-cycle press/release pulses for the game core ui_in inputs.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .ena         (ena),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a DEBOUNCE_CYCLES=4 and a DEBOUNCE_CYCLES=1
// instance share one stimulus and are checked every cycle against a
// window-based model, plus hand-computed scenario checks.
module tb_button_conditioner;
    import button_pkg::*;

    localparam int N    = 4;
    localparam int DC_A = 4;
    localparam int DC_B = 1;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena   = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] lvl_a, prs_a, rls_a;
    logic [N-1:0] lvl_b, prs_b, rls_b;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // Model: per edge, the filter sees the raw value sampled two edges earlier.
    // A channel flips when the last DC edges were all enabled and all saw a
    // value different from the current level.
    logic [N-1:0] raw_hist[$];
    logic [N-1:0] samp_hist[$];
    logic         ena_hist[$];
    int           n_edges = 0;
    logic [N-1:0] exp_lvl[2] = '{default: '0};
    logic [N-1:0] exp_prs[2] = '{default: '0};
    logic [N-1:0] exp_rls[2] = '{default: '0};

    button_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(DC_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn_raw(btn_raw),
        .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rls_a)
    );

    button_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(DC_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn_raw(btn_raw),
        .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rls_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_hist.delete();
            samp_hist.delete();
            ena_hist.delete();
            n_edges = 0;
            for (int k = 0; k < 2; k++) begin
                exp_lvl[k] = '0;
                exp_prs[k] = '0;
                exp_rls[k] = '0;
            end
        end else begin
            n_edges++;
            raw_hist.push_back(btn_raw);
            if (n_edges >= 3) samp_hist.push_back(raw_hist[raw_hist.size() - 3]);
            else              samp_hist.push_back('0);
            ena_hist.push_back(ena);
            if (raw_hist.size() > 8)  void'(raw_hist.pop_front());
            if (samp_hist.size() > 8) void'(samp_hist.pop_front());
            if (ena_hist.size() > 8)  void'(ena_hist.pop_front());
            for (int k = 0; k < 2; k++) begin
                int win;
                win = (k == 0) ? DC_A : DC_B;
                for (int c = 0; c < N; c++) begin
                    bit accept;
                    accept = (n_edges >= win);
                    if (accept) begin
                        for (int j = 0; j < win; j++) begin
                            int idx;
                            idx = samp_hist.size() - 1 - j;
                            if (!ena_hist[idx] || samp_hist[idx][c] == exp_lvl[k][c]) accept = 1'b0;
                        end
                    end
                    exp_prs[k][c] = accept && !exp_lvl[k][c];
                    exp_rls[k][c] = accept && exp_lvl[k][c];
                    if (accept) exp_lvl[k][c] = ~exp_lvl[k][c];
                end
            end
        end
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("a_level",   lvl_a, exp_lvl[0]);
            check("a_press",   prs_a, exp_prs[0]);
            check("a_release", rls_a, exp_rls[0]);
            check("b_level",   lvl_b, exp_lvl[1]);
            check("b_press",   prs_b, exp_prs[1]);
            check("b_release", rls_b, exp_rls[1]);
        end
    end

    // Returns just after the falling edge following n more rising edges.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Mid-cycle asynchronous reset: outputs must clear before any clock edge.
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        check("rst_level",   lvl_a, '0);
        check("rst_press",   prs_a, '0);
        check("rst_release", rls_a, '0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pat;
        ena     = 1'b1;
        btn_raw = '0;
        tick(2);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        tick(3);

        // Reset and full latency with all buttons held
        btn_raw = 4'hF;
        tick(8);
        check("pre_rst_level", lvl_a, 4'hF);
        async_reset();
        tick(5);
        check("t1_level_e5", lvl_a, 4'h0);
        tick();
        check("t1_level_e6",   lvl_a, 4'hF);
        check("t1_press_e6",   prs_a, 4'hF);
        check("t1_release_e6", rls_a, 4'h0);
        tick();
        check("t1_press_e7", prs_a, 4'h0);

        btn_raw = 4'h0;
        tick(6);
        check("all_release", rls_a, 4'hF);

        // Clean press/release on channel 0
        btn_raw = 4'b0001;
        tick(5);
        check("t2_level_e5", lvl_a, 4'b0000);
        tick();
        check("t2_level_e6", lvl_a, 4'b0001);
        check("t2_press_e6", prs_a, 4'b0001);
        tick(2);
        btn_raw = 4'b0000;
        tick(6);
        check("t2_release_e6", rls_a, 4'b0001);
        check("t2_level_low",  lvl_a, 4'b0000);

        // Bounce on channel 1: 1,1,1,0 then steady 1s
        pat = 8'b1111_0111;
        for (int j = 0; j < 8; j++) begin
            btn_raw[BTN_LEFT] = pat[j];
            tick();
        end
        tick();
        check("t3_level_e9", lvl_a, 4'b0000);
        tick();
        check("t3_level_e10", lvl_a, 4'b0010);
        check("t3_press_e10", prs_a, 4'b0010);
        btn_raw = '0;
        tick(8);

        // Three-cycle glitch on channel 2
        btn_raw[BTN_RIGHT] = 1'b1;
        tick(3);
        btn_raw[BTN_RIGHT] = 1'b0;
        tick(8);
        check("t4_glitch_level", lvl_a, 4'b0000);

        // ena drop after two pending counts on channel 3
        btn_raw = 4'b1000;
        tick(4);
        ena = 1'b0;
        tick(3);
        check("t5_ena_off_level", lvl_a, 4'b0000);
        ena = 1'b1;
        tick(3);
        check("t5_ena_on_e3", lvl_a, 4'b0000);
        tick();
        check("t5_ena_on_e4", lvl_a, 4'b1000);
        check("t5_press_e4",  prs_a, 4'b1000);

        // Reset while channels 0 and 3 are pending
        btn_raw = 4'b0001;
        tick(4);
        async_reset();
        tick(5);
        check("t5_rst_e5", lvl_a, 4'b0000);
        tick();
        check("t5_rst_e6",   lvl_a, 4'b0001);
        check("t5_rst_prs6", prs_a, 4'b0001);
        tick(2);

        // Channels 0 and 3 change on the same edge; DC=1 instance flips at edge 3
        btn_raw = 4'b1000;
        tick(2);
        check("t6_b_level_e2", lvl_b, 4'b0001);
        tick();
        check("t6_b_level_e3",   lvl_b, 4'b1000);
        check("t6_b_press_e3",   prs_b, 4'b1000);
        check("t6_b_release_e3", rls_b, 4'b0001);
        tick(3);
        check("t6_a_level_e6",   lvl_a, 4'b1000);
        check("t6_a_press_e6",   prs_a, 4'b1000);
        check("t6_a_release_e6", rls_a, 4'b0001);

        // Randomised phase: bursts of bouncing, quiet holds, ena dips, resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int change_pct;
            change_pct = ((cyc / 200) % 2 == 0) ? 30 : 4;
            if ($urandom_range(0, 99) < change_pct) btn_raw = btn_raw ^ 4'($urandom);
            ena = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        tick(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the raw, asynchronous board push-buttons before they reach the game core's `ui_in` inputs. Each button is:

- synchronised into the `clk` domain,
- debounced with a stable-count filter,
- turned into a clean level plus one-cycle press and release pulses.

It sits directly upstream of the game core, between the board pins and `ui_in[3:0]`.

## Interface

Parameters:
- `N_BTN`, 4: number of independent button channels.
- `DEBOUNCE_CYCLES`, 250000: consecutive agreeing samples required to accept a new level. The default gives 10 ms at 25 MHz. Legal range ≥ 1.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width. Derived; not overridden.

Ports:
- `clk`, input, 1: single clock. All logic is on its rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `ena`, input, 1: design enable. When low, the filter is frozen.
- `btn_raw`, input, N_BTN: raw buttons, active-high, asynchronous to `clk`.
- `btn_level`, output, N_BTN: debounced level, registered.
- `btn_press`, output, N_BTN: one-cycle pulse when `btn_level` goes 0→1, registered.
- `btn_release`, output, N_BTN: one-cycle pulse when `btn_level` goes 1→0, registered.

## Operation

Channels are fully independent and identical. Per channel:

- **Synchroniser:** two flops, `sync1` ← `btn_raw[i]`, `sync2` ← `sync1`. It runs regardless of `ena`.
- **Filter state:**
  - STABLE: `cnt` == 0.
  - PENDING: `cnt` > 0.
- **Each edge with `ena`=1:**
  - If `sync2` == `btn_level[i]`: `cnt` ← 0, go to STABLE. This applies to any bounce back, at any point in PENDING.
  - Else if `cnt` == DEBOUNCE_CYCLES−1:
    - `btn_level[i]` ← `sync2`, `cnt` ← 0, go to STABLE.
    - Pulse `btn_press[i]` if the new level is 1, `btn_release[i]` if it is 0.
  - Else: `cnt` ← `cnt`+1, go to or stay in PENDING.
- **Each edge with `ena`=0:**
  - `cnt` ← 0.
  - `btn_level` holds.
  - `btn_press` and `btn_release` are 0.
- **Pulses:** `btn_press` and `btn_release` are 0 on every edge that does not flip the level. They are never both high on one channel in the same cycle.
- **`DEBOUNCE_CYCLES` == 1:** the filter degenerates to a pure 2-flop synchroniser with edge pulses.
- **Counter width:** `cnt` never exceeds DEBOUNCE_CYCLES−1, so there is no wrap-around.

## Timing

- **Reset values** (while `rst_n`=0, immediately and asynchronously):
  - `sync1`, `sync2` = 0.
  - `cnt` = 0.
  - `btn_level` = 0, `btn_press` = 0, `btn_release` = 0.
- **Reset mid-PENDING:** the pending change is discarded. After reset release, a still-held button needs the full DEBOUNCE_CYCLES+2 latency again.
- **Latency:**
  - Number the first rising edge that samples a new, stable raw value as edge 1.
  - `sync2` shows the new value after edge 2.
  - `btn_level` flips and the pulse asserts after edge DEBOUNCE_CYCLES+2.
  - The pulse deasserts after the following edge.
- **Glitch rejection:** a raw glitch shorter than DEBOUNCE_CYCLES consecutive `sync2` samples never changes `btn_level`.
- **Simultaneous channels:** simultaneous changes on different channels are processed independently in the same cycle.
- **`ena` interactions:**
  - `ena` falling mid-PENDING discards the count.
  - `ena` rising restarts counting from 0 on the next edge.
- **No handshake:** consumers sample every cycle.

## Structure

- **Shared package `button_pkg`:**
  - Channel index constants `BTN_UP`=0, `BTN_LEFT`=1, `BTN_RIGHT`=2, `BTN_DOWN`=3. These match the game core `ui_in[3:0]` order.
  - `N_BTN_DEFAULT`=4.
  - `DEBOUNCE_CYCLES_DEFAULT`=250000.
- **Sub-module `debounce_channel`:** one button's synchroniser, counter and pulse logic. The top instantiates it N_BTN times in a generate loop.
- **No shared state** between channels.

## Test plan

Benches run with `DEBOUNCE_CYCLES`=4 and `N_BTN`=4 unless a scenario says otherwise.

1. **Reset:** assert `rst_n`=0 asynchronously mid-cycle with `btn_raw`=4'hF → all outputs 0 immediately. Release, hold 4'hF → `btn_level`=4'hF and `btn_press`=4'hF for exactly one cycle after edge 6. `btn_release` stays 0.
2. **Clean press/release on channel 0:** raw 0→1 sampled at edge 1 → level 1 and `press[0]` pulse after edge 6. Raw 1→0 later → `release[0]` pulse 6 edges after the first low sample. Other channels stay 0.
3. **Bounce:** raw pattern 1,1,1,0,1,1,1,1 on channel 1 → the counter resets on the 0. Level rises 6 edges after the final run of 1s starts, not before. Exactly one `press[1]` pulse.
4. **Glitch:** 3-cycle raw high pulse on channel 2 → `btn_level[2]` stays 0 and no pulses occur.
5. **`ena` and reset mid-operation:**
   - Drop `ena` after 2 PENDING counts → no flip. Restore `ena` → flip occurs 4 edges later.
   - Assert `rst_n` mid-PENDING → outputs 0, full latency of 6 required again.
6. **Independence:** channels 0 and 3 change on the same edge → both flip on the same edge and both pulse in the same cycle. `DEBOUNCE_CYCLES`=1 run → flip after edge 3.
